add_sub_serial: RTL and testbench

//  Multi-cycle, parametrised two's-complement adder/subtractor for the ALU datapath.

---
 rtl/add_sub_pkg.sv | 15 +
 rtl/add_sub_chunk.sv | 24 ++
 rtl/add_sub_serial.sv | 138 +++++++++++++
 tb/tb_add_sub_serial.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// Shared constants for the serial adder/subtractor.
//   OP_ADD / OP_SUB : encodings of the op input
//   state_e         : control FSM state encoding (IDLE -> RUN -> DONE)
package add_sub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/add_sub_chunk.sv
// One CHUNK-bit slice of the ripple adder, purely combinational.
//   a, b  : chunk operands (b already inverted for subtract)
//   cin   : carry into bit 0 of the chunk
//   s     : chunk sum
//   cout  : carry out of bit CHUNK-1
//   c_msb : carry into bit CHUNK-1 (used for signed overflow on the last chunk)
module add_sub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

  // Sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out
  // without a second (CHUNK-1)-bit adder; also works for CHUNK == 1.
  assign c_msb = s[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/add_sub_serial.sv
// Multi-cycle two's-complement adder/subtractor, CHUNK bits per clock.
//   clk, reset        : clock (rising edge), async active-high reset
//   start, op, A, B   : request; sampled only in IDLE (op 0 = A+B, 1 = A-B)
//   busy              : high in RUN and DONE
//   done              : one-cycle pulse; R and flags valid in that cycle
//   R                 : result, held until the next operation completes
//   carryOut          : add: carry out; sub: 1 = no borrow
//   overflow          : signed overflow
//   zero, negative    : R == 0, R[WIDTH-1]
module add_sub_serial
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R,
  output logic             carryOut,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if ((WIDTH < 1) || (CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_cfg
    $error("add_sub_serial: CHUNK must divide WIDTH");
  end

  state_e                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [NCHUNK-1:0][CHUNK-1:0]  a_q, a_d, bx_q, bx_d, sh_q, sh_d;
  logic                          carry_q, carry_d;
  logic [WIDTH-1:0]              r_q, r_d;
  logic                          co_q, co_d, ov_q, ov_d, z_q, z_d, n_q, n_d;

  logic [CHUNK-1:0] sum;
  logic             cout, c_msb;

  add_sub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_q[cnt_q]),
    .b     (bx_q[cnt_q]),
    .cin   (carry_q),
    .s     (sum),
    .cout  (cout),
    .c_msb (c_msb)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    bx_d    = bx_q;
    sh_d    = sh_q;
    carry_d = carry_q;
    r_d     = r_q;
    co_d    = co_q;
    ov_d    = ov_q;
    z_d     = z_q;
    n_d     = n_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // Subtract is A + ~B + 1: invert B here and seed the carry with op.
          a_d     = A;
          bx_d    = B ^ {WIDTH{op}};
          carry_d = op;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sh_d[cnt_q] = sum;
        carry_d     = cout;
        if (cnt_q == LAST) begin
          // Last chunk: publish result and flags on the DONE entry edge.
          cnt_d   = '0;
          state_d = S_DONE;
          r_d     = sh_d;
          co_d    = cout;
          ov_d    = c_msb ^ cout;
          z_d     = (sh_d == '0);
          n_d     = sh_d[NCHUNK-1][CHUNK-1];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      bx_q    <= '0;
      sh_q    <= '0;
      carry_q <= 1'b0;
      r_q     <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      bx_q    <= bx_d;
      sh_q    <= sh_d;
      carry_q <= carry_d;
      r_q     <= r_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
      z_q     <= z_d;
      n_q     <= n_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign R        = r_q;
  assign carryOut = co_q;
  assign overflow = ov_q;
  assign zero     = z_q;
  assign negative = n_q;

endmodule

// File: tb/tb_add_sub_serial.sv
// Self-checking bench for add_sub_serial (WIDTH=32, CHUNK=8): directed
// cases, start-while-busy, mid-operation reset, and a random sweep checked
// against an arithmetic reference model.
module tb_add_sub_serial;

  localparam int W = 32;
  localparam int C = 8;
  localparam int N = W / C;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done, carryOut, overflow, zero, negative;
  logic [W-1:0] R;

  int n_assert = 0;
  int n_fail   = 0;

  add_sub_serial #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .R(R), .carryOut(carryOut),
    .overflow(overflow), .zero(zero), .negative(negative)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {R, carryOut, overflow, zero, negative} from plain arithmetic.
  function automatic logic [W+3:0] model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic [W:0]   wide;
    logic         c, v;
    longint       sa, sb, t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o) begin
      r = a - b;
      c = (a >= b);
      t = sa - sb;
    end else begin
      wide = {1'b0, a} + {1'b0, b};
      r = wide[W-1:0];
      c = wide[W];
      t = sa + sb;
    end
    v = (t != longint'($signed(r)));
    return {r, c, v, (r == '0), r[W-1]};
  endfunction

  function automatic logic [W+3:0] outs();
    return {R, carryOut, overflow, zero, negative};
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = 32'h8000_0000;
      3:       v = 32'h7FFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Entered just after a negedge with the DUT idle. Returns after the
  // cycle following done (DUT idle again).
  task automatic run_op(input string tag, input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W+3:0] exp;
    int lat;
    exp   = model(o, a, b);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
    op    = 1'($urandom);
    A     = $urandom;
    B     = $urandom;
    lat   = 1;
    while (!done && lat < N + 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(N + 1));
    chk({tag, " busy@done"}, 64'(busy), 64'd1);
    chk({tag, " result"}, 64'(outs()), 64'(exp));
    @(negedge clk);
    chk({tag, " idle after"}, 64'({busy, done}), 64'd0);
  endtask

  initial begin
    logic [W-1:0] a1, b1, a2, b2;
    // Reset state
    @(negedge clk);
    chk("reset outs", 64'({busy, done, outs()}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op("t1 carry across chunk", 1'b0, 32'h0000_00FF, 32'h0000_0001);
    run_op("t2 5-7", 1'b1, 32'd5, 32'd7);
    run_op("t2 7-7", 1'b1, 32'd7, 32'd7);
    run_op("t3 max+1", 1'b0, 32'h7FFF_FFFF, 32'd1);
    run_op("t3 -1+1", 1'b0, 32'hFFFF_FFFF, 32'd1);
    run_op("sub min-1", 1'b1, 32'h8000_0000, 32'd1);

    // start held high cycles 0..7; operands changed from cycle 2
    a1 = 32'h1234_5678; b1 = 32'h1111_1111;
    a2 = 32'h0000_0010; b2 = 32'h0000_0003;
    for (int c = 0; c < 14; c++) begin
      start = (c <= 7);
      if (c < 2) begin op = 1'b0; A = a1; B = b1; end
      else       begin op = 1'b1; A = a2; B = b2; end
      chk($sformatf("t4 done c%0d", c), 64'(done), 64'(c == 5 || c == 11));
      if (c == 5)  chk("t4 first result", 64'(outs()), 64'(model(1'b0, a1, b1)));
      if (c == 11) chk("t4 second result", 64'(outs()), 64'(model(1'b1, a2, b2)));
      @(negedge clk);
    end
    start = 1'b0;

    // Reset mid-operation (R is nonzero from the previous op)
    start = 1'b1; op = 1'b0; A = 32'hAAAA_0000; B = 32'h0000_5555;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t5 reset outs", 64'({busy, done, outs()}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < N + 3; c++) begin
      chk($sformatf("t5 no done c%0d", c), 64'({busy, done}), 64'd0);
      @(negedge clk);
    end
    run_op("t5 after reset", 1'b0, 32'hAAAA_0000, 32'h0000_5555);

    // Random sweep
    for (int i = 0; i < 1000; i++) begin
      logic o;
      logic [W-1:0] ra, rb;
      o  = 1'($urandom);
      ra = pick();
      rb = pick();
      run_op($sformatf("rand%0d", i), o, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
